branch_redirect_unit: RTL and testbench
=======================================

Name: branch_redirect_unit

Overview:
Consumes the resolved branch decision from the execute-stage branch comparator and steers the fetch PC.
- Owns the fetch PC register and sequences PC+4 advance.
- Captures taken-branch targets and holds them until the instruction cache/fetch side can accept a new address.
- Issues a one-cycle pipeline flush and keeps a saturating taken-branch counter for performance monitoring.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h0000_1000, fetch PC value after reset
CNT_W, 16, width of taken-branch counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
ex_valid  in  1  execute stage holds a resolved branch this cycle
ex_branch  in  1  branch comparator result (1 = taken); ignored when ex_valid=0
ex_target  in  XLEN  branch target address
fetch_ready  in  1  fetch/icache can accept a new PC this cycle (0 during a miss)
stall  in  1  downstream stall; blocks sequential PC advance only
pc  out  XLEN  current fetch PC
flush  out  1  one-cycle pulse: squash younger in-flight instructions
redirect_pending  out  1  a taken target is latched but not yet applied
misaligned  out  1  one-cycle pulse: taken target had target[1:0] != 0
taken_count  out  CNT_W  saturating count of accepted taken branches

Behaviour:
- One clock; reset is synchronous and active-high, on clk and reset. All state updates on the rising edge of clk.
- Reset values: pc=RESET_PC, flush=0, redirect_pending=0, misaligned=0, taken_count=0, state=IDLE, pending target=0.
- Reset wins over every other input in the same cycle, including mid-PENDING: the latched target is discarded.
- States:
  - IDLE: no pending redirect.
  - PENDING: a target is latched and waiting for fetch_ready.
- IDLE, no taken branch (ex_valid=0, or ex_branch=0): if fetch_ready=1 and stall=0 then pc<=pc+4, wrapping modulo 2^XLEN. Otherwise pc holds.
- IDLE, ex_valid=1 and ex_branch=1 in cycle N. This redirect has priority over sequential advance and ignores stall.
  - fetch_ready=1 in N: pc=ex_target&~3 at N+1; state stays IDLE.
  - fetch_ready=0 in N: latch ex_target&~3; state=PENDING at N+1; pc holds.
  - In both cases: flush=1 in N+1 only; taken_count increments, saturating at all-ones; misaligned=1 in N+1 if ex_target[1:0] != 0.
- PENDING:
  - redirect_pending=1 (a registered output that equals state==PENDING).
  - pc holds.
  - At the first cycle M with fetch_ready=1: pc=latched target at M+1; state=IDLE at M+1.
  - No second flush is issued.
- ex_valid=1 while in PENDING: ignored. It is a wrong-path instruction already covered by the flush; it does not change the target and is not counted.
- Simultaneous events: if the PENDING exit (fetch_ready=1) coincides with ex_valid=1, ex_valid is still ignored in that cycle.
- Not-taken branch: behaves exactly as no branch; no flush, no count change.
- Latency: taken branch to new pc is 1 cycle when fetch_ready=1. Otherwise it is 1 cycle after the first fetch_ready.
- All outputs are registered; no combinational input-to-output paths.

Decomposition:
- Shared package branch_pkg:
  - redirect state enum {IDLE, PENDING};
  - RESET_PC default;
  - branch operation codes shared with the comparator: BR_NONE=4'b0000, BR_EQ=4'b0001, BR_GT=4'b0010, BR_GE=4'b0011;
  - PC_STEP=4.
- One natural sub-module: sat_counter (parameterised width, increment enable, synchronous reset), used for taken_count.

Test Plan:
- Reset then fetch_ready=1, stall=0 for 3 cycles -> pc = 0x1000, 0x1004, 0x1008, 0x100C; flush=0 throughout.
- Cycle N: ex_valid=1, ex_branch=1, ex_target=0x2000, fetch_ready=1 -> N+1: pc=0x2000, flush=1, taken_count=1; N+2: flush=0, pc=0x2004.
- Cycle N: taken branch to 0x3000 with fetch_ready=0 held 4 cycles -> N+1: flush=1, redirect_pending=1, pc unchanged. While waiting, assert ex_valid=1, ex_branch=1, ex_target=0x4000 -> ignored. Raise fetch_ready at N+4 -> N+5: pc=0x3000, redirect_pending=0, taken_count=1.
- ex_valid=1, ex_branch=0, ex_target=0x5000 -> pc advances by 4; flush=0; taken_count unchanged.
- Taken branch with ex_target=0x2002 -> pc=0x2000, misaligned=1 and flush=1 for one cycle.
- Enter PENDING with target 0x6000, assert reset -> next cycle pc=0x1000, redirect_pending=0, taken_count=0. With CNT_W=4, 20 taken branches -> taken_count saturates at 15.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: definitions shared by the branch comparator and the redirect
// unit. It holds the redirect state encoding, the reset PC default, the
// comparator operation codes and the sequential PC step.
package branch_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } redir_state_t;

    localparam logic [31:0] BR_RESET_PC = 32'h0000_1000;

    typedef enum logic [3:0] {
        BR_NONE = 4'b0000,
        BR_EQ   = 4'b0001,
        BR_GT   = 4'b0010,
        BR_GE   = 4'b0011
    } br_op_t;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/branch_redirect_unit_sat_counter.sv
// sat_counter: up-counter that stops at all-ones and clears on a synchronous reset.
//   clk   : rising-edge clock
//   reset : synchronous, active-high clear
//   inc   : when high, count advances by one unless it is already saturated
//   count : current count (registered)
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit: owns the fetch PC. It advances the PC sequentially by
// PC_STEP and applies resolved taken-branch targets. A target that arrives
// while fetch cannot accept it is held until fetch_ready. Each accepted taken
// branch produces a one-cycle flush and is counted.
//   clk, reset        : clock and synchronous active-high reset
//   ex_valid          : execute stage presents a resolved branch
//   ex_branch         : branch taken (only meaningful with ex_valid)
//   ex_target         : branch target address
//   fetch_ready       : fetch side can accept a new PC this cycle
//   stall             : blocks sequential advance (not redirects)
//   pc                : current fetch PC
//   flush             : one-cycle squash pulse after an accepted taken branch
//   redirect_pending  : a taken target is latched and waiting for fetch_ready
//   misaligned        : one-cycle pulse when the taken target had low bits set
//   taken_count       : saturating count of accepted taken branches
module branch_redirect_unit
    import branch_pkg::*;
#(
    parameter int unsigned         XLEN     = 32,
    parameter logic [XLEN-1:0]     RESET_PC = BR_RESET_PC,
    parameter int unsigned         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             fetch_ready,
    input  logic             stall,
    output logic [XLEN-1:0]  pc,
    output logic             flush,
    output logic             redirect_pending,
    output logic             misaligned,
    output logic [CNT_W-1:0] taken_count
);

    redir_state_t    state;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] aligned_target;
    logic            take;

    // Branches seen while PENDING are wrong-path and already covered by the flush.
    assign take           = (state == IDLE) && ex_valid && ex_branch;
    assign aligned_target = {ex_target[XLEN-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            pc               <= RESET_PC;
            target           <= '0;
            flush            <= 1'b0;
            misaligned       <= 1'b0;
            redirect_pending <= 1'b0;
        end else begin
            flush      <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        flush      <= 1'b1;
                        misaligned <= |ex_target[1:0];
                        if (fetch_ready) begin
                            pc <= aligned_target;
                        end else begin
                            target           <= aligned_target;
                            state            <= PENDING;
                            redirect_pending <= 1'b1;
                        end
                    end else if (fetch_ready && !stall) begin
                        pc <= pc + XLEN'(PC_STEP);
                    end
                end
                PENDING: begin
                    if (fetch_ready) begin
                        pc               <= target;
                        state            <= IDLE;
                        redirect_pending <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (take),
        .count (taken_count)
    );

endmodule

// File: tb/tb_branch_redirect_unit.sv
module tb_branch_redirect_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_branch;
    logic [31:0] ex_target;
    logic        fetch_ready;
    logic        stall;

    logic [31:0] pc_a, pc_b;
    logic        flush_a, flush_b, rp_a, rp_b, mis_a, mis_b;
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Narrow counter instance exercises saturation; wide one the default width.
    branch_redirect_unit #(.XLEN(32), .RESET_PC(32'h0000_1000), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_branch(ex_branch),
        .ex_target(ex_target), .fetch_ready(fetch_ready), .stall(stall),
        .pc(pc_a), .flush(flush_a), .redirect_pending(rp_a),
        .misaligned(mis_a), .taken_count(cnt_a)
    );

    branch_redirect_unit #(.XLEN(32), .RESET_PC(32'h0000_1000), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_branch(ex_branch),
        .ex_target(ex_target), .fetch_ready(fetch_ready), .stall(stall),
        .pc(pc_b), .flush(flush_b), .redirect_pending(rp_b),
        .misaligned(mis_b), .taken_count(cnt_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the fetch PC and status must be after each edge.
    bit          m_valid = 0;
    bit          m_pend;
    longint      m_pc;
    longint      m_tgt;
    bit          m_flush, m_mis;
    int          m_taken;

    always @(posedge clk) begin
        bit taken;
        if (reset) begin
            m_valid = 1;
            m_pc    = 64'h1000;
            m_pend  = 0;
            m_tgt   = 0;
            m_flush = 0;
            m_mis   = 0;
            m_taken = 0;
        end else if (m_valid) begin
            taken   = !m_pend && ex_valid && ex_branch;
            m_flush = taken;
            m_mis   = taken && ((ex_target % 4) != 0);
            if (taken) begin
                m_taken++;
                if (fetch_ready) m_pc = ex_target - (ex_target % 4);
                else begin
                    m_pend = 1;
                    m_tgt  = ex_target - (ex_target % 4);
                end
            end else if (m_pend) begin
                if (fetch_ready) begin
                    m_pc   = m_tgt;
                    m_pend = 0;
                end
            end else if (fetch_ready && !stall) begin
                m_pc = (m_pc + 4) % 64'h1_0000_0000;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cmp pc_a",  pc_a,  32'(m_pc));
            chk("cmp pc_b",  pc_b,  32'(m_pc));
            chk("cmp flush_a", {31'd0, flush_a}, {31'd0, m_flush});
            chk("cmp flush_b", {31'd0, flush_b}, {31'd0, m_flush});
            chk("cmp pend_a", {31'd0, rp_a}, {31'd0, m_pend});
            chk("cmp pend_b", {31'd0, rp_b}, {31'd0, m_pend});
            chk("cmp mis_a", {31'd0, mis_a}, {31'd0, m_mis});
            chk("cmp mis_b", {31'd0, mis_b}, {31'd0, m_mis});
            chk("cmp cnt_a", {28'd0, cnt_a}, (m_taken > 15) ? 32'd15 : 32'(m_taken));
            chk("cmp cnt_b", {16'd0, cnt_b}, (m_taken > 65535) ? 32'd65535 : 32'(m_taken));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic v, input logic t, input logic [31:0] tgt);
        ex_valid  = v;
        ex_branch = t;
        ex_target = tgt;
    endtask

    initial begin
        reset = 1'b1; fetch_ready = 1'b0; stall = 1'b0;
        br(0, 0, 32'h0);
        cyc(); cyc();
        chk("reset pc", pc_a, 32'h1000);
        chk("reset pend", {31'd0, rp_a}, 32'd0);
        chk("reset cnt", {16'd0, cnt_b}, 32'd0);
        reset = 1'b0; fetch_ready = 1'b1;

        cyc(); chk("seq pc1", pc_a, 32'h1004);
        cyc(); chk("seq pc2", pc_a, 32'h1008);
        cyc(); chk("seq pc3", pc_b, 32'h100C);
        chk("seq flush", {31'd0, flush_a}, 32'd0);

        // Taken branch with fetch ready.
        br(1, 1, 32'h2000);
        cyc(); chk("tk pc", pc_a, 32'h2000); chk("tk flush", {31'd0, flush_a}, 32'd1);
        chk("tk cnt", {16'd0, cnt_b}, 32'd1);
        br(0, 0, 32'h0);
        cyc(); chk("tk flush off", {31'd0, flush_a}, 32'd0); chk("tk pc+4", pc_a, 32'h2004);

        // Taken branch while fetch is busy; later branches ignored.
        fetch_ready = 1'b0; br(1, 1, 32'h3000);
        cyc(); chk("pend flush", {31'd0, flush_a}, 32'd1); chk("pend rp", {31'd0, rp_a}, 32'd1);
        chk("pend pc hold", pc_a, 32'h2004);
        br(1, 1, 32'h4000);
        cyc(); chk("pend ign flush", {31'd0, flush_b}, 32'd0); chk("pend ign cnt", {16'd0, cnt_b}, 32'd2);
        cyc();
        fetch_ready = 1'b1;   // exit coincides with ex_valid, which must still be ignored
        cyc(); chk("pend exit pc", pc_a, 32'h3000); chk("pend exit rp", {31'd0, rp_a}, 32'd0);
        chk("pend exit cnt", {16'd0, cnt_b}, 32'd2);
        br(0, 0, 32'h0);
        cyc(); chk("post pend pc", pc_a, 32'h3004);

        // Not-taken branch behaves like no branch.
        br(1, 0, 32'h5000);
        cyc(); chk("nt pc", pc_a, 32'h3008); chk("nt flush", {31'd0, flush_a}, 32'd0);
        br(0, 0, 32'h0);

        // Stall holds sequential advance but not a redirect.
        stall = 1'b1;
        cyc(); chk("stall pc", pc_a, 32'h3008);
        br(1, 1, 32'h2002);
        cyc(); chk("mis pc", pc_a, 32'h2000); chk("mis flag", {31'd0, mis_a}, 32'd1);
        chk("mis flush", {31'd0, flush_a}, 32'd1);
        br(0, 0, 32'h0); stall = 1'b0;
        cyc(); chk("mis off", {31'd0, mis_a}, 32'd0); chk("mis pc+4", pc_a, 32'h2004);

        // Reset in the middle of a pending redirect discards the target.
        fetch_ready = 1'b0; br(1, 1, 32'h6000);
        cyc(); chk("rst pend rp", {31'd0, rp_b}, 32'd1);
        br(0, 0, 32'h0); reset = 1'b1;
        cyc(); chk("rst pend pc", pc_a, 32'h1000); chk("rst pend rp0", {31'd0, rp_a}, 32'd0);
        chk("rst pend cnt", {28'd0, cnt_a}, 32'd0);
        reset = 1'b0; fetch_ready = 1'b1;
        cyc(); chk("rst resume pc", pc_a, 32'h1004);

        // Saturation of the narrow counter.
        for (int i = 1; i <= 20; i++) begin
            br(1, 1, 32'(i) << 8);
            cyc();
        end
        chk("sat cnt4", {28'd0, cnt_a}, 32'd15);
        chk("sat cnt16", {16'd0, cnt_b}, 32'd20);

        // Sequential wrap at the top of the address space.
        br(1, 1, 32'hFFFF_FFFC);
        cyc(); chk("wrap top", pc_a, 32'hFFFF_FFFC);
        br(0, 0, 32'h0);
        cyc(); chk("wrap zero", pc_a, 32'h0000_0000);
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
